// File: rtl/stage_execute.sv
// EX pipeline stage: single-cycle ALU ops, a 32-iteration multiply/divide unit
// with HI/LO registers, and the EX/MEM pipeline register.
module stage_execute (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_e,
    input  logic        flush_e,
    input  logic [3:0]  alucontrol_e,
    input  logic [31:0] srca_e,
    input  logic [31:0] srcb_e,
    input  logic [31:0] writedata_e,
    input  logic        memwrite_e,
    input  logic        regwrite_e,
    input  logic        memtoreg_e,
    input  logic [4:0]  writereg_e,
    output logic [31:0] aluout_m,
    output logic [31:0] writedata_m,
    output logic        memwrite_m,
    output logic        regwrite_m,
    output logic        memtoreg_m,
    output logic        valid_m,
    output logic [4:0]  writereg_m,
    output logic        stall_e,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} mdState_t;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;

    mdState_t    state_q;
    logic [4:0]  count_q;
    logic [63:0] acc_q;
    logic [31:0] operand_q;
    logic        negRes_q, negRem_q, divZero_q;
    logic [31:0] hi_q, lo_q;

    logic [31:0] aluout_q, writedata_q;
    logic [4:0]  writereg_q;
    logic        memwrite_q, regwrite_q, memtoreg_q, valid_q;

    logic        isMulDiv, isDivOp, signedOp, isMoveHiLo, advance, startMd;
    logic        negA, negB;
    logic [31:0] magA, magB, result;
    logic [32:0] mulSum, divShift;
    logic        divGeq;
    logic [31:0] divRem;
    logic [63:0] mulNext, divNext, mulProd;
    logic [31:0] finalHi, finalLo;

    assign isMulDiv   = (alucontrol_e == OP_MULT) || (alucontrol_e == OP_MULTU) ||
                        (alucontrol_e == OP_DIV)  || (alucontrol_e == OP_DIVU);
    assign isDivOp    = (alucontrol_e == OP_DIV)  || (alucontrol_e == OP_DIVU);
    assign signedOp   = (alucontrol_e == OP_MULT) || (alucontrol_e == OP_DIV);
    assign isMoveHiLo = (alucontrol_e == OP_MFHI) || (alucontrol_e == OP_MFLO);

    assign busy    = (state_q != IDLE);
    assign stall_e = valid_e & ~flush_e & busy & (isMulDiv | isMoveHiLo);
    assign advance = valid_e & ~flush_e & ~stall_e;
    assign startMd = advance & isMulDiv;

    assign negA = signedOp & srca_e[31];
    assign negB = signedOp & srcb_e[31];
    assign magA = negA ? -srca_e : srca_e;
    assign magB = negB ? -srcb_e : srcb_e;

    always_comb begin
        result = 32'd0;
        case (alucontrol_e)
            OP_AND:  result = srca_e & srcb_e;
            OP_OR:   result = srca_e | srcb_e;
            OP_ADD:  result = srca_e + srcb_e;
            OP_SUB:  result = srca_e - srcb_e;
            OP_SLT:  result = {31'd0, $signed(srca_e) < $signed(srcb_e)};
            OP_MFHI: result = hi_q;
            OP_MFLO: result = lo_q;
            default: result = 32'd0;
        endcase
    end

    // One iteration of each algorithm; acc_q holds {partial, multiplier} or {remainder, quotient}.
    always_comb begin
        mulSum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, operand_q} : 33'd0);
        mulNext  = {mulSum, acc_q[31:1]};
        divShift = {acc_q[63:32], acc_q[31]};
        divGeq   = divShift >= {1'b0, operand_q};
        divRem   = divGeq ? (divShift[31:0] - operand_q) : divShift[31:0];
        divNext  = {divRem, acc_q[30:0], divGeq};
        mulProd  = negRes_q ? -mulNext : mulNext;
        finalLo  = divZero_q ? 32'hFFFF_FFFF : (negRes_q ? -divNext[31:0] : divNext[31:0]);
        finalHi  = negRem_q ? -divNext[63:32] : divNext[63:32];
    end

    // Multiply/divide sequencer; HI/LO only change on the final iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            acc_q     <= 64'd0;
            operand_q <= 32'd0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startMd) begin
                        state_q   <= isDivOp ? DIV : MUL;
                        count_q   <= 5'd0;
                        acc_q     <= {32'd0, isDivOp ? magA : magB};
                        operand_q <= isDivOp ? magB : magA;
                        negRes_q  <= negA ^ negB;
                        negRem_q  <= negA;
                        divZero_q <= (srcb_e == 32'd0);
                    end
                end
                MUL: begin
                    acc_q   <= mulNext;
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_q <= IDLE;
                        hi_q    <= mulProd[63:32];
                        lo_q    <= mulProd[31:0];
                    end
                end
                DIV: begin
                    acc_q   <= divNext;
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_q <= IDLE;
                        hi_q    <= finalHi;
                        lo_q    <= finalLo;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // EX/MEM register; mult/div ops travel on as a valid bubble that writes nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            aluout_q    <= 32'd0;
            writedata_q <= 32'd0;
            writereg_q  <= 5'd0;
            memwrite_q  <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            aluout_q    <= result;
            writedata_q <= writedata_e;
            writereg_q  <= writereg_e;
            valid_q     <= advance;
            regwrite_q  <= advance & regwrite_e & ~isMulDiv;
            memwrite_q  <= advance & memwrite_e & ~isMulDiv;
            memtoreg_q  <= advance & memtoreg_e & ~isMulDiv;
        end
    end

    assign aluout_m    = aluout_q;
    assign writedata_m = writedata_q;
    assign writereg_m  = writereg_q;
    assign memwrite_m  = memwrite_q;
    assign regwrite_m  = regwrite_q;
    assign memtoreg_m  = memtoreg_q;
    assign valid_m     = valid_q;
endmodule

// File: tb/tb_stage_execute.sv
// Self-checking bench for stage_execute: directed scenarios with literal results,
// then random traffic compared every cycle against an arithmetic reference model.
module tb_stage_execute;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;

    logic        clk = 1'b0;
    logic        reset, valid_e, flush_e, memwrite_e, regwrite_e, memtoreg_e;
    logic [3:0]  alucontrol_e;
    logic [31:0] srca_e, srcb_e, writedata_e;
    logic [4:0]  writereg_e;
    logic [31:0] aluout_m, writedata_m;
    logic        memwrite_m, regwrite_m, memtoreg_m, valid_m, stall_e, busy;
    logic [4:0]  writereg_m;

    int checkCount = 0;
    int failCount  = 0;

    stage_execute dut (
        .clk(clk), .reset(reset), .valid_e(valid_e), .flush_e(flush_e),
        .alucontrol_e(alucontrol_e), .srca_e(srca_e), .srcb_e(srcb_e),
        .writedata_e(writedata_e), .memwrite_e(memwrite_e), .regwrite_e(regwrite_e),
        .memtoreg_e(memtoreg_e), .writereg_e(writereg_e), .aluout_m(aluout_m),
        .writedata_m(writedata_m), .memwrite_m(memwrite_m), .regwrite_m(regwrite_m),
        .memtoreg_m(memtoreg_m), .valid_m(valid_m), .writereg_m(writereg_m),
        .stall_e(stall_e), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: {HI,LO} a mult/div must produce, from plain integer arithmetic.
    function automatic logic [63:0] mdModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = 64'd0;
        case (op)
            OP_MULT:  p = sa * sb;
            OP_MULTU: p = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    function automatic logic [31:0] aluModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] hi, input logic [31:0] lo);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_MFHI: return hi;
            OP_MFLO: return lo;
            default: return 32'd0;
        endcase
    endfunction

    logic        modelReady = 1'b0;
    logic        expValid, expRegwrite, expMemwrite, expMemtoreg, expCheckData, expCheckMtr;
    logic [31:0] expAluout, expWritedata, hiM, loM;
    logic [4:0]  expWritereg;
    logic [63:0] pendingM;
    int          mdRemain = 0;

    // Compare on the falling edge, then advance the model using the inputs held for this cycle.
    always @(negedge clk) begin
        logic isMd, isMf, expStall, go;
        isMd = (alucontrol_e inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
        isMf = (alucontrol_e inside {OP_MFHI, OP_MFLO});
        expStall = valid_e && !flush_e && (mdRemain != 0) && (isMd || isMf);
        if (modelReady) begin
            checkOutput("valid_m", 32'(valid_m), 32'(expValid));
            checkOutput("regwrite_m", 32'(regwrite_m), 32'(expRegwrite));
            checkOutput("memwrite_m", 32'(memwrite_m), 32'(expMemwrite));
            if (expCheckMtr) checkOutput("memtoreg_m", 32'(memtoreg_m), 32'(expMemtoreg));
            if (expCheckData) begin
                checkOutput("aluout_m", aluout_m, expAluout);
                checkOutput("writedata_m", writedata_m, expWritedata);
                checkOutput("writereg_m", 32'(writereg_m), 32'(expWritereg));
            end
            checkOutput("busy", 32'(busy), 32'(mdRemain != 0));
            checkOutput("stall_e", 32'(stall_e), 32'(expStall));
        end
        if (reset) begin
            modelReady = 1'b1;
            {expValid, expRegwrite, expMemwrite, expMemtoreg} = 4'b0;
            expAluout = 32'd0; expWritedata = 32'd0; expWritereg = 5'd0;
            expCheckData = 1'b1; expCheckMtr = 1'b1;
            hiM = 32'd0; loM = 32'd0; mdRemain = 0;
        end else begin
            go = valid_e && !flush_e && !expStall;
            expValid     = go;
            expRegwrite  = go && regwrite_e && !isMd;
            expMemwrite  = go && memwrite_e && !isMd;
            expMemtoreg  = go && memtoreg_e;
            expCheckMtr  = !(go && isMd);
            expCheckData = go && !isMd;
            expAluout    = aluModel(alucontrol_e, srca_e, srcb_e, hiM, loM);
            expWritedata = writedata_e;
            expWritereg  = writereg_e;
            if (go && isMd) begin
                pendingM = mdModel(alucontrol_e, srca_e, srcb_e);
                mdRemain = 32;
            end else if (mdRemain != 0) begin
                mdRemain--;
                if (mdRemain == 0) {hiM, loM} = pendingM;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setInputs(input logic v, input logic f, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic rw, input logic [4:0] wr);
        valid_e = v; flush_e = f; alucontrol_e = op; srca_e = a; srcb_e = b;
        regwrite_e = rw; writereg_e = wr; memwrite_e = 1'b0; memtoreg_e = 1'b0;
        writedata_e = 32'hA5A5_0000 | 32'(wr);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic rw, input logic [4:0] wr);
        setInputs(1'b1, 1'b0, op, a, b, rw, wr);
        tick();
    endtask

    task automatic waitIdle();
        setInputs(1'b0, 1'b0, OP_AND, 32'd0, 32'd0, 1'b0, 5'd0);
        for (int i = 0; i < 40 && busy; i++) tick();
        checkOutput("idleReached", 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int stallCount;
        reset = 1'b1;
        setInputs(1'b0, 1'b0, OP_AND, 32'd0, 32'd0, 1'b0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("resetAluout", aluout_m, 32'd0);
        checkOutput("resetValid", 32'(valid_m), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);

        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd5);
        checkOutput("addWrap", aluout_m, 32'h8000_0000);
        checkOutput("addRegwrite", 32'(regwrite_m), 32'd1);
        checkOutput("addWritereg", 32'(writereg_m), 32'd5);

        applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd6);
        checkOutput("sltNegPos", aluout_m, 32'd1);
        applyStimulus(OP_SLT, 32'd1, 32'hFFFF_FFFF, 1'b1, 5'd6);
        checkOutput("sltPosNeg", aluout_m, 32'd0);

        applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 5'd8);
        checkOutput("multBubbleRegwrite", 32'(regwrite_m), 32'd0);
        checkOutput("multBubbleValid", 32'(valid_m), 32'd1);
        setInputs(1'b1, 1'b0, OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd9);
        stallCount = 0;
        for (int i = 0; i < 40 && stall_e; i++) begin
            stallCount++;
            tick();
        end
        checkOutput("multStallCycles", 32'(stallCount), 32'd32);
        tick();
        checkOutput("multLo", aluout_m, 32'hFFFF_FFEB);
        applyStimulus(OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd10);
        checkOutput("multHi", aluout_m, 32'hFFFF_FFFF);

        applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1, 5'd11);
        setInputs(1'b1, 1'b0, OP_ADD, 32'd3, 32'd4, 1'b1, 5'd12);
        checkOutput("addDuringBusyStall", 32'(stall_e), 32'd0);
        checkOutput("addDuringBusyBusy", 32'(busy), 32'd1);
        tick();
        checkOutput("addDuringBusyResult", aluout_m, 32'd7);
        waitIdle();
        applyStimulus(OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd13);
        checkOutput("divuLo", aluout_m, 32'd14);
        applyStimulus(OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd13);
        checkOutput("divuHi", aluout_m, 32'd2);

        applyStimulus(OP_DIV, 32'd5, 32'd0, 1'b1, 5'd14);
        waitIdle();
        applyStimulus(OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd14);
        checkOutput("divZeroLo", aluout_m, 32'hFFFF_FFFF);
        applyStimulus(OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd14);
        checkOutput("divZeroHi", aluout_m, 32'd5);

        applyStimulus(OP_MULTU, 32'd12345, 32'd6789, 1'b1, 5'd15);
        setInputs(1'b0, 1'b0, OP_AND, 32'd0, 32'd0, 1'b0, 5'd3);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("busyBeforeAbort", 32'(busy), 32'd1);
        reset = 1'b1;
        setInputs(1'b1, 1'b1, OP_ADD, 32'd1, 32'd2, 1'b1, 5'd7);
        tick();
        reset = 1'b0;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortAluout", aluout_m, 32'd0);
        checkOutput("abortWritereg", 32'(writereg_m), 32'd0);
        checkOutput("abortRegwrite", 32'(regwrite_m), 32'd0);
        applyStimulus(OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd1);
        checkOutput("abortHi", aluout_m, 32'd0);
        applyStimulus(OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd1);
        checkOutput("abortLo", aluout_m, 32'd0);

        // Random traffic; the falling-edge model checks every cycle.
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            setInputs($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)),
                      pickOperand(), pickOperand(), 1'($urandom), 5'($urandom));
            memwrite_e = 1'($urandom);
            memtoreg_e = 1'($urandom);
            writedata_e = $urandom;
            tick();
        end
        reset = 1'b0;
        waitIdle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        failCount++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/stage_execute.md
STAGE_EXECUTE -- requirements
Module: stage_execute

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- valid_e  in  1  EX instruction valid
- flush_e  in  1  kill EX instruction (bubble)
- alucontrol_e  in  4  operation select
- srca_e, srcb_e  in  32  operands
- writedata_e  in  32  store data
- memwrite_e, regwrite_e, memtoreg_e  in  1  control
- writereg_e  in  5  destination register
- aluout_m  out  32  registered result / data address
- writedata_m  out  32  registered store data
- memwrite_m, regwrite_m, memtoreg_m, valid_m  out  1  registered control
- writereg_m  out  5  registered destination
- stall_e  out  1  combinational; hold EX and upstream
- busy  out  1  mult/div unit active
REQ-002 SHALL use one clock, clk; reset SHALL be synchronous and active-high, port named reset.

Function
REQ-003 SHALL decode alucontrol_e: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU, 1100 MFHI, 1101 MFLO; other codes produce result 0.
REQ-004 ADD/SUB SHALL wrap modulo 2^32; no overflow exception; SLT result 1 or 0.
REQ-005 Single-cycle ops SHALL register result into aluout_m, with all _e fields copied to _m, on the next clk edge (latency 1).
REQ-006 Mult/div unit SHALL have states IDLE, MUL, DIV; busy = (state != IDLE).
REQ-007 MULT/MULTU/DIV/DIVU accepted in cycle N (valid_e, !flush_e, !stall_e) SHALL go IDLE->MUL or IDLE->DIV, load a 5-bit counter, and iterate one bit per cycle for cycles N+1..N+32.
REQ-008 At end of cycle N+32 state SHALL return to IDLE and {HI,LO} SHALL update; MFHI/MFLO in cycle N+33 SHALL see new values.
REQ-009 MUL SHALL be shift-add on magnitudes; DIV SHALL be restoring on magnitudes; signed variants SHALL negate product (sign a^b), quotient (sign a^b) and remainder (sign of dividend) at completion.
REQ-010 Divide by zero SHALL give LO=32'hFFFFFFFF, HI=dividend, still 32 cycles.
REQ-011 Mult/div ops SHALL retire to MEM as bubble: regwrite_m=0, memwrite_m=0, valid_m=1.
REQ-012 stall_e SHALL be 1 iff valid_e & !flush_e & busy & op in {MULT..DIVU, MFHI, MFLO}; other ops proceed while busy.
REQ-013 When stall_e=1 or flush_e=1 or valid_e=0, next MEM register SHALL be bubble: valid_m, regwrite_m, memwrite_m, memtoreg_m = 0; data fields don't-care.
REQ-014 flush_e SHALL NOT cancel an in-progress mult/div.
REQ-015 MFHI/MFLO SHALL register HI/LO into aluout_m with regwrite_e passed through.

Reset
REQ-016 reset=1 at a clk edge SHALL clear all _m outputs, HI, LO, counter to 0 and state to IDLE; busy and stall_e = 0 the following cycle.
REQ-017 reset mid-operation SHALL abort the mult/div; HI/LO read 0 afterwards.
REQ-018 reset SHALL dominate valid_e and flush_e in the same cycle.

Verification
REQ-019 ADD 32'h7FFFFFFF+1, regwrite_e=1, writereg_e=5 -> next cycle aluout_m=32'h80000000, regwrite_m=1, writereg_m=5.
REQ-020 SLT -1,1 -> aluout_m=1; SLT 1,-1 -> aluout_m=0.
REQ-021 MULT -3,7 then MFLO back-to-back -> stall_e=1 for 32 cycles, then aluout_m=32'hFFFFFFEB; MFHI -> 32'hFFFFFFFF.
REQ-022 DIVU 100,7 with independent ADD during busy -> ADD not stalled; later MFLO=14, MFHI=2.
REQ-023 DIV 5,0 -> LO=32'hFFFFFFFF, HI=5 after 32 cycles.
REQ-024 reset asserted at iteration 10 of MULTU -> busy=0, MFHI and MFLO both 0, _m outputs 0.
